// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the shared UART transmit arbiter.
// Handshakes: requester i's byte transfers in the cycle req_accept[i] is high, and req_data
// slice i must stay stable until then. tx_wr is a one-cycle strobe issued only while tx_ack is high.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_lock;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_accept;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   timeout_flag;
  logic [7:0]         tx_data;
  logic               tx_wr;
  logic               tx_ack;

  modport slave (
    input  req_valid, req_lock, req_data, tx_ack,
    output req_accept, grant, timeout_flag, tx_data, tx_wr
  );

  modport master (
    output req_valid, req_lock, req_data, tx_ack,
    input  req_accept, grant, timeout_flag, tx_data, tx_wr
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte streams,
// with per-requester frame lock and an idle-lock timeout that forces release.
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus,
  output logic [1:0]       dbg_state
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = 10;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_LO, WAIT_HI} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] req_accept_q, req_accept_d;
  logic [N_REQ-1:0] timeout_flag_q, timeout_flag_d;
  logic [PW-1:0]    gidx_q, gidx_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [1:0]       ack_cnt_q, ack_cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_wr_q, tx_wr_d;

  logic             sel_found;
  logic [PW-1:0]    sel_idx;
  logic [PW-1:0]    cand;
  logic [7:0]       cur_byte;
  logic             release_now;
  int               j;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    j         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      cand = PW'(j);
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx_q == PW'(i)) cur_byte = bus.req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    gidx_d         = gidx_q;
    rr_ptr_d       = rr_ptr_q;
    idle_cnt_d     = idle_cnt_q;
    ack_cnt_d      = ack_cnt_q;
    tx_data_d      = tx_data_q;
    tx_wr_d        = 1'b0;
    req_accept_d   = '0;
    timeout_flag_d = timeout_flag_q;
    release_now    = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_found && !tx_wr_q) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          gidx_d           = sel_idx;
          idle_cnt_d       = '0;
          state_d          = SEND;
        end
      end
      SEND: begin
        if (bus.req_valid[gidx_q] && bus.tx_ack) begin
          tx_data_d              = cur_byte;
          tx_wr_d                = 1'b1;
          req_accept_d[gidx_q]   = 1'b1;
          idle_cnt_d             = '0;
          timeout_flag_d[gidx_q] = 1'b0;
          ack_cnt_d              = '0;
          state_d                = WAIT_LO;
        end else if (!bus.req_valid[gidx_q]) begin
          if (bus.req_lock[gidx_q]) begin
            // Saturating idle count; the release lands on the LOCK_TIMEOUT-th idle cycle.
            if (idle_cnt_q >= CW'(LOCK_TIMEOUT - 1)) begin
              idle_cnt_d             = CW'(LOCK_TIMEOUT);
              timeout_flag_d[gidx_q] = 1'b1;
              release_now            = 1'b1;
            end else begin
              idle_cnt_d = idle_cnt_q + 1'b1;
            end
          end else begin
            release_now = 1'b1;
          end
        end
      end
      WAIT_LO: begin
        // A transmitter that never drops ack still counts the byte as taken after 4 cycles.
        if (!bus.tx_ack || ack_cnt_q == 2'd3) begin
          state_d = WAIT_HI;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      WAIT_HI: begin
        if (bus.tx_ack) begin
          if (bus.req_lock[gidx_q]) state_d = SEND;
          else                      release_now = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_now) begin
      grant_d  = '0;
      rr_ptr_d = (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      gidx_q         <= '0;
      rr_ptr_q       <= '0;
      idle_cnt_q     <= '0;
      ack_cnt_q      <= '0;
      tx_data_q      <= '0;
      tx_wr_q        <= 1'b0;
      req_accept_q   <= '0;
      timeout_flag_q <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      gidx_q         <= gidx_d;
      rr_ptr_q       <= rr_ptr_d;
      idle_cnt_q     <= idle_cnt_d;
      ack_cnt_q      <= ack_cnt_d;
      tx_data_q      <= tx_data_d;
      tx_wr_q        <= tx_wr_d;
      req_accept_q   <= req_accept_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.req_accept   = req_accept_q;
  assign bus.timeout_flag = timeout_flag_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_wr        = tx_wr_q;
  assign dbg_state        = state_q;
endmodule
